// File: rtl/ped_request_ctrl_if.sv
// Signal bundle between the pedestrian push-button front end and its neighbours.
// The front end uses the slave view. The board/controller side uses the master view.
interface ped_request_ctrl_if;
    logic       btn_raw;
    logic       ped_ack;
    logic       ped_req;
    logic       btn_clean;
    logic       led_wait;
    logic [3:0] extra_press;

    modport master (
        output btn_raw,
        output ped_ack,
        input  ped_req,
        input  btn_clean,
        input  led_wait,
        input  extra_press
    );

    modport slave (
        input  btn_raw,
        input  ped_ack,
        output ped_req,
        output btn_clean,
        output led_wait,
        output extra_press
    );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian button front end: sync, debounce, latch a crossing request until
// acknowledged, then ignore the button for a cooldown period.
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int COOLDOWN_CYCLES = 125000000,
    parameter int CNT_W           = 28
) (
    input  logic               clk,
    input  logic               rst,
    ped_request_ctrl_if.slave  bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_MAX = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               btn_clean_q, btn_clean_d;
    logic               btn_prev_q, btn_prev_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0]   cd_cnt_q, cd_cnt_d;
    logic               ped_req_q, ped_req_d;
    logic [3:0]         extra_q, extra_d;
    logic               press;

    always_comb begin
        s1_d        = bus.btn_raw;
        s2_d        = s1_q;
        btn_prev_d  = btn_clean_q;
        btn_clean_d = btn_clean_q;
        db_cnt_d    = '0;
        // Any cycle where the synced level agrees with the clean level restarts the count.
        if (s2_q != btn_clean_q) begin
            if (db_cnt_q == DB_MAX) begin
                btn_clean_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        press = btn_clean_q & ~btn_prev_q;
    end

    always_comb begin
        state_d  = state_q;
        extra_d  = extra_q;
        cd_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PENDING;
                    extra_d = 4'd0;
                end
            end
            PENDING: begin
                // Ack wins over a coincident press; that press is simply lost.
                if (bus.ped_ack) begin
                    state_d = COOLDOWN;
                end else if (press && (extra_q != 4'd15)) begin
                    extra_d = extra_q + 4'd1;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_q == CD_MAX) begin
                    state_d = IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ped_req_d = (state_d == PENDING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            btn_clean_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            db_cnt_q    <= '0;
            cd_cnt_q    <= '0;
            ped_req_q   <= 1'b0;
            extra_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            btn_clean_q <= btn_clean_d;
            btn_prev_q  <= btn_prev_d;
            db_cnt_q    <= db_cnt_d;
            cd_cnt_q    <= cd_cnt_d;
            ped_req_q   <= ped_req_d;
            extra_q     <= extra_d;
        end
    end

    assign bus.ped_req     = ped_req_q;
    assign bus.led_wait    = ped_req_q;
    assign bus.btn_clean   = btn_clean_q;
    assign bus.extra_press = extra_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with short debounce/cooldown times.
// Expected output vectors are {ped_req, led_wait, btn_clean, extra_press}.
module tb_ped_request_ctrl;
    localparam int DEB  = 4;
    localparam int COOL = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [6:0] exp_q[$];
    int         checks;
    int         failures;

    ped_request_ctrl_if bus ();

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .COOLDOWN_CYCLES (COOL),
        .CNT_W           (28)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic req, input logic clean, input logic [3:0] extra);
        exp_q.push_back({req, req, clean, extra});
    endtask

    task automatic check_out(input string tag);
        logic [6:0] obs;
        logic [6:0] e;
        obs = {bus.ped_req, bus.led_wait, bus.btn_clean, bus.extra_press};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%b expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, e);
            end
        end
    endtask

    // One full clean press and debounced release while the clock runs.
    task automatic do_press();
        bus.btn_raw = 1'b1;
        tick(8);
        bus.btn_raw = 1'b0;
        tick(8);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.btn_raw = 1'b0;
        bus.ped_ack = 1'b0;

        tick(3);
        push_exp(1'b0, 1'b0, 4'd0);
        check_out("reset");
        rst_n = 1'b1;
        tick(2);

        // Clean press: first sampled at edge k, clean after k+5, request after k+6.
        bus.btn_raw = 1'b1;
        push_exp(1'b0, 1'b0, 4'd0);
        tick(5);
        check_out("clean_before");
        push_exp(1'b0, 1'b1, 4'd0);
        tick(1);
        check_out("clean_rise");
        push_exp(1'b1, 1'b1, 4'd0);
        tick(1);
        check_out("req_rise");
        push_exp(1'b1, 1'b1, 4'd0);
        tick(5);
        check_out("req_hold");
        bus.btn_raw = 1'b0;
        push_exp(1'b1, 1'b0, 4'd0);
        tick(8);
        check_out("release");

        // 17 presses while pending saturate the extra counter at 15.
        for (int i = 1; i <= 17; i++) begin
            push_exp(1'b1, 1'b0, (i > 15) ? 4'd15 : 4'(i));
            do_press();
            check_out("extra_press");
        end

        bus.ped_ack = 1'b1;
        tick(1);
        bus.ped_ack = 1'b0;
        push_exp(1'b0, 1'b0, 4'd15);
        check_out("ack_drop");
        push_exp(1'b0, 1'b0, 4'd15);
        tick(10);
        check_out("cooldown_done");

        // Bounce: 2-cycle pulses never pass the debouncer.
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = ~bus.btn_raw;
            push_exp(1'b0, 1'b0, 4'd15);
            tick(2);
            check_out("bounce");
        end
        bus.btn_raw = 1'b0;
        push_exp(1'b0, 1'b0, 4'd15);
        tick(8);
        check_out("bounce_settle");

        // Fresh request from idle clears the extra counter.
        bus.btn_raw = 1'b1;
        push_exp(1'b1, 1'b1, 4'd0);
        tick(7);
        check_out("reentry_clear");
        bus.btn_raw = 1'b0;
        push_exp(1'b1, 1'b0, 4'd0);
        tick(8);
        check_out("reentry_release");

        // Press completing at a+3 lands in cooldown and is dropped.
        bus.btn_raw = 1'b1;
        tick(3);
        bus.ped_ack = 1'b1;
        tick(1);
        bus.ped_ack = 1'b0;
        push_exp(1'b0, 1'b0, 4'd0);
        check_out("cd_ack");
        push_exp(1'b0, 1'b1, 4'd0);
        tick(3);
        check_out("cd_press_seen");
        bus.btn_raw = 1'b0;
        push_exp(1'b0, 1'b0, 4'd0);
        tick(7);
        check_out("cd_ignore");

        // New request plus one extra press, then press edge at a+9 after ack.
        bus.btn_raw = 1'b1;
        push_exp(1'b1, 1'b1, 4'd0);
        tick(7);
        check_out("req2");
        bus.btn_raw = 1'b0;
        tick(8);
        push_exp(1'b1, 1'b0, 4'd1);
        do_press();
        check_out("req2_extra");
        bus.ped_ack = 1'b1;
        tick(1);
        bus.ped_ack = 1'b0;
        tick(2);
        bus.btn_raw = 1'b1;
        tick(5);
        push_exp(1'b0, 1'b1, 4'd1);
        tick(1);
        check_out("cd_last");
        push_exp(1'b1, 1'b1, 4'd0);
        tick(1);
        check_out("cd_exit_press");
        bus.btn_raw = 1'b0;
        push_exp(1'b1, 1'b0, 4'd0);
        tick(8);
        check_out("cd_exit_release");

        // Press edge coincides with ack: go to cooldown, press not counted.
        bus.btn_raw = 1'b1;
        tick(6);
        bus.ped_ack = 1'b1;
        tick(1);
        bus.ped_ack = 1'b0;
        push_exp(1'b0, 1'b1, 4'd0);
        check_out("simul");
        bus.btn_raw = 1'b0;
        push_exp(1'b0, 1'b0, 4'd0);
        tick(16);
        check_out("simul_settle");

        // Asynchronous reset in the middle of a pending request.
        bus.btn_raw = 1'b1;
        push_exp(1'b1, 1'b1, 4'd0);
        tick(7);
        check_out("pre_reset_req");
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 4'd0);
        check_out("async_rst");
        tick(1);
        rst_n = 1'b1;
        push_exp(1'b0, 1'b0, 4'd0);
        tick(5);
        check_out("post_rst_wait");
        push_exp(1'b0, 1'b1, 4'd0);
        tick(1);
        check_out("post_rst_clean");
        push_exp(1'b1, 1'b1, 4'd0);
        tick(1);
        check_out("post_rst_req");
        push_exp(1'b1, 1'b1, 4'd0);
        tick(10);
        check_out("post_rst_hold");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
